// File: rtl/ddr_sample_merge.sv
// ---------------------------------------------------------------------------
// ddr_sample_merge
//   Takes the rising-edge (indata) and falling-edge (indata180) samples from
//   ddr_inbuf and serialises them, in time order, into one WIDTH-bit stream.
//   The stream is held in a small first-word-fall-through FIFO and is handed
//   to the core sampler over a valid/ready handshake.
//
// Ports
//   clk        system clock, shared with ddr_inbuf
//   reset_n    synchronous active-low reset
//   clear      synchronous flush: empties the FIFO and clears overflow
//   ddr_mode   1 = push indata and indata180 per cycle, 0 = indata only
//   in_valid   the current indata/indata180 pair is a sample to accept
//   indata     rising-edge sample, chronologically first
//   indata180  falling-edge sample, chronologically second
//   out_ready  downstream accepts dataout this cycle
//   out_valid  dataout holds a valid sample
//   dataout    head-of-FIFO sample (don't-care while out_valid = 0)
//   count      number of samples currently held (0..DEPTH)
//   overflow   sticky: at least one push was dropped since reset/clear
// ---------------------------------------------------------------------------
module ddr_sample_merge #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       ddr_mode,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           indata,
  input  logic [WIDTH-1:0]           indata180,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           dataout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic             r_overflow;

  logic [CW-1:0]    w_need;
  logic [CW-1:0]    w_free;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;
  logic [AW-1:0]    w_wr_p1;
  logic [AW-1:0]    w_wr_next;
  logic [AW-1:0]    w_rd_next;
  logic [CW-1:0]    w_count_next;

  // Credit comes from the registered count only: a pop in the same cycle
  // does not make room for the push, which keeps the compare off the
  // out_ready path.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    w_need       = '0;
    w_push       = 1'b0;
    w_drop       = 1'b0;
    w_wr_next    = r_wr;
    w_rd_next    = r_rd;
    w_count_next = r_count;

    if (in_valid) w_need = ddr_mode ? CW'(2) : CW'(1);
    w_free = CW'(DEPTH) - r_count;

    // A pair is accepted whole or dropped whole, never split.
    if (in_valid) begin
      if (w_need <= w_free) w_push = 1'b1;
      else                  w_drop = 1'b1;
    end

    w_pop = r_valid && out_ready;

    if (w_push) begin
      w_wr_next    = r_wr + w_need[AW-1:0];
      w_count_next = w_count_next + w_need;
    end
    if (w_pop) begin
      w_rd_next    = r_rd + AW'(1);
      w_count_next = w_count_next - CW'(1);
    end
  end

  assign w_wr_p1 = r_wr + AW'(1);

  // NOTE: control state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wr       <= w_wr_next;
      r_rd       <= w_rd_next;
      r_count    <= w_count_next;
      // Registered alongside count so out_valid == (count != 0) always.
      r_valid    <= (w_count_next != '0);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // NOTE: the sample storage is deliberately not reset; its contents are
  // only observable behind a valid pointer, and leaving it out of reset
  // lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (reset_n && !clear && w_push) begin
      r_mem[r_wr] <= indata;
      if (ddr_mode) r_mem[w_wr_p1] <= indata180;
    end
  end

  assign out_valid = r_valid;
  assign dataout   = r_mem[r_rd];
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_ddr_sample_merge.sv
module tb_ddr_sample_merge;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             clear;
  logic             ddr_mode;
  logic             in_valid;
  logic [WIDTH-1:0] indata;
  logic [WIDTH-1:0] indata180;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] dataout;
  logic [3:0]       count;
  logic             overflow;

  int n_cmp = 0;
  int n_bad = 0;

  ddr_sample_merge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .ddr_mode  (ddr_mode),
    .in_valid  (in_valid),
    .indata    (indata),
    .indata180 (indata180),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .dataout   (dataout),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        clr;
    logic        ddr;
    logic        iv;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        rdy;
    logic        e_valid;
    logic [3:0]  e_count;
    logic        e_ovf;
    logic        chk_d;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst_n, input logic clr, input logic ddr, input logic iv,
                     input logic [31:0] d0, input logic [31:0] d1, input logic rdy,
                     input logic e_valid, input logic [3:0] e_count, input logic e_ovf,
                     input logic chk_d, input logic [31:0] e_data);
    vec_t v;
    v = '{rst_n, clr, ddr, iv, d0, d1, rdy, e_valid, e_count, e_ovf, chk_d, e_data};
    vecs.push_back(v);
  endtask

  task automatic idle();
    reset_n = 1'b1; clear = 1'b0; ddr_mode = 1'b0; in_valid = 1'b0;
    indata = '0; indata180 = '0; out_ready = 1'b0;
  endtask

  initial begin
    idle();

    // 1. reset then idle
    reset_n = 1'b0;
    step();
    check("reset valid", 32'(out_valid), 32'd0);
    check("reset count", 32'(count), 32'd0);
    check("reset ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle valid", 32'(out_valid), 32'd0);
      check("idle count", 32'(count), 32'd0);
      check("idle ovf", 32'(overflow), 32'd0);
    end

    // Table: inputs applied before an edge, outputs expected after it.
    //   rst clr ddr iv  d0     d1     rdy  valid cnt ovf chk data
    // 2. one DDR pair, drained in order
    add(1, 0, 1, 1, 32'hA1, 32'hB2, 1,   1, 2, 0, 1, 32'hA1);
    add(1, 0, 1, 0, 32'h0,  32'h0,  1,   1, 1, 0, 1, 32'hB2);
    add(1, 0, 1, 0, 32'h0,  32'h0,  1,   0, 0, 0, 0, 32'h0);
    // 4. fill to 7, then DDR push + pop: push dropped, pop proceeds
    add(1, 0, 1, 1, 32'h10, 32'h11, 0,   1, 2, 0, 1, 32'h10);
    add(1, 0, 1, 1, 32'h12, 32'h13, 0,   1, 4, 0, 1, 32'h10);
    add(1, 0, 1, 1, 32'h14, 32'h15, 0,   1, 6, 0, 1, 32'h10);
    add(1, 0, 0, 1, 32'h16, 32'h0,  0,   1, 7, 0, 1, 32'h10);
    add(1, 0, 1, 1, 32'h20, 32'h21, 1,   1, 6, 1, 1, 32'h11);
    add(1, 0, 1, 0, 32'h0,  32'h0,  1,   1, 5, 1, 1, 32'h12);
    // 6a. clear at count 5 (push+pop discarded), next push comes out first
    add(1, 1, 1, 1, 32'h50, 32'h51, 1,   0, 0, 0, 0, 32'h0);
    add(1, 0, 1, 1, 32'h30, 32'h31, 0,   1, 2, 0, 1, 32'h30);
    add(1, 0, 1, 1, 32'h32, 32'h33, 0,   1, 4, 0, 1, 32'h30);
    add(1, 0, 0, 1, 32'h34, 32'h0,  0,   1, 5, 0, 1, 32'h30);
    // 6b. reset at count 5 overrides push and pop
    add(0, 0, 1, 1, 32'h60, 32'h61, 1,   0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 1, 32'h40, 32'h0,  0,   1, 1, 0, 1, 32'h40);
    add(1, 0, 0, 0, 32'h0,  32'h0,  1,   0, 0, 0, 0, 32'h0);
    // empty with out_ready=1: no pop, then a fresh pair comes out in order
    add(1, 0, 0, 0, 32'h0,  32'h0,  1,   0, 0, 0, 0, 32'h0);
    add(1, 0, 1, 1, 32'h70, 32'h71, 0,   1, 2, 0, 1, 32'h70);
    add(1, 0, 1, 0, 32'h0,  32'h0,  1,   1, 1, 0, 1, 32'h71);
    add(1, 0, 1, 0, 32'h0,  32'h0,  1,   0, 0, 0, 0, 32'h0);

    foreach (vecs[i]) begin
      reset_n = vecs[i].rst_n; clear = vecs[i].clr; ddr_mode = vecs[i].ddr;
      in_valid = vecs[i].iv; indata = vecs[i].d0; indata180 = vecs[i].d1;
      out_ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
      if (vecs[i].chk_d)
        check($sformatf("vec%0d data", i), dataout, vecs[i].e_data);
    end
    idle();

    // 3. five DDR pairs into a stalled FIFO: four fit, fifth dropped
    ddr_mode = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      indata = 32'h100 + 32'(2 * k);
      indata180 = 32'h101 + 32'(2 * k);
      step();
      check($sformatf("fill%0d count", k), 32'(count), (k < 4) ? 32'(2 * (k + 1)) : 32'd8);
      check($sformatf("fill%0d ovf", k), 32'(overflow), (k == 4) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d valid", i), 32'(out_valid), 32'd1);
      check($sformatf("drain%0d data", i), dataout, 32'h100 + 32'(i));
      step();
    end
    check("drained valid", 32'(out_valid), 32'd0);
    check("drained count", 32'(count), 32'd0);
    check("ovf sticky", 32'(overflow), 32'd1);

    // reset clears the sticky overflow
    out_ready = 1'b0; reset_n = 1'b0;
    step();
    check("rst ovf clr", 32'(overflow), 32'd0);
    reset_n = 1'b1;

    // 5. SDR stream 0..19 with out_ready=1: one-deep pass-through, pointers wrap
    ddr_mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      indata = 32'(i);
      step();
      check($sformatf("sdr%0d data", i), dataout, 32'(i));
      check($sformatf("sdr%0d count", i), 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("sdr end count", 32'(count), 32'd0);
    check("sdr end ovf", 32'(overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
